mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the 5-stage pipeline, directly downstream of the execute stage. Captures the EX/MEM pipeline register (ALU result, store data, destination, WB/M control) and performs load/store accesses over a variable-latency req/ack data-memory port. Stalls execute while an access is outstanding, times out hung accesses, and produces the MEM/WB register plus forwarding taps for the EX forwarding unit.

## Interface

Parameters:
- TIMEOUT_CYCLES, 255: max wait cycles for dmem_ack before the access is abandoned (1..65535).

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  EX presents an instruction this cycle.
- in_ready  out  1  stage accepts; 0 stalls EX and everything upstream.
- WB_in  in  1  register-write enable of the instruction.
- M_in  in  3  {mem_to_reg, mem_write, mem_read}.
- alu_result  in  16  ALU output; memory word address for loads/stores.
- store_data  in  16  forwarded rt value for stores.
- dst  in  4  destination register.
- dmem_req  out  1  access request; held until ack or timeout.
- dmem_we  out  1  1 = write, 0 = read; valid with dmem_req.
- dmem_addr  out  16  word address; valid with dmem_req.
- dmem_wdata  out  16  write data; valid with dmem_req.
- dmem_ack  in  1  access complete this cycle; dmem_rdata valid when read.
- dmem_rdata  in  16  read data.
- wb_valid  out  1  MEM/WB register holds an instruction.
- wb_regwrite  out  1  write register file this cycle.
- wb_dst  out  4  register-file write address.
- wb_data  out  16  register-file write data.
- fwd_mem_valid  out  1  EX/MEM holds a forwardable ALU result.
- fwd_mem_dst  out  4  its destination.
- fwd_mem_data  out  16  its value (alu_result).
- mem_err  out  1  sticky: a timeout occurred; cleared only by rst.

## Operation

- Capture: on a rising edge with in_valid & in_ready, S1 (EX/MEM) loads all inputs; with in_ready & ~in_valid, S1 becomes invalid (bubble).
- S1 is a memory op when mem_read | mem_write. Both set: treated as write, regwrite suppressed.
- FSM (sub-module) states: IDLE, WAIT. IDLE: if S1 valid memory op, dmem_req=1 combinationally; ack that cycle completes it (zero-wait); otherwise next state WAIT. WAIT: dmem_req held with stable we/addr/wdata; ack -> IDLE; wait counter == TIMEOUT_CYCLES -> IDLE with timeout.
- in_ready = ~(S1 valid & memory op & ~dmem_ack & ~timeout).
- Completion: S2 (MEM/WB) loads when S1 is valid and (non-memory op, or ack, or timeout); otherwise S2 becomes invalid.
- wb_data = mem_to_reg ? dmem_rdata (captured at ack) : alu_result. Timeout: wb_data = 16'hDEAD, wb_regwrite=0, mem_err set.
- wb_regwrite = WB & ~write-op & (dst != 0) & ~timeout; R0 is hardwired zero.
- fwd_mem_valid = S1 valid & WB & ~mem_to_reg & dst != 0; loads never forward from S1 (hazard unit inserts the bubble).
- Simultaneous ack and timeout count reached: ack wins, no error.

## Timing

- Reset: all valids 0, dmem_req 0, dmem_we 0, addr/wdata/wb_data/fwd_mem_data 0, dsts 0, wb_regwrite 0, mem_err 0, FSM IDLE, counter 0.
- Non-memory op: captured edge N, visible in MEM/WB after edge N+1 (1-cycle stage latency).
- Memory op, ack k cycles after first req cycle (k=0 zero-wait): MEM/WB after edge N+1+k; in_ready low for k cycles.
- Timeout: req deasserts after TIMEOUT_CYCLES+1 request cycles; op retires at that edge.
- Reset mid-access: req drops immediately (async), transaction abandoned, no write-back.
- Counter resets to 0 on each new access.

## Structure

- Shared package cpu_pkg: M-bit index constants (M_READ=0, M_WRITE=1, M_TOREG=2), FSM state enum {IDLE, WAIT}, constant MEM_TIMEOUT_DATA=16'hDEAD.
- One sub-module: mem_access_fsm (state, wait counter, dmem_req/ack/timeout); mem_stage holds S1, S2, muxes and forwarding.

## Test plan

- ALU op dst=3 alu_result=16'h1234 WB=1 -> fwd_mem valid next cycle, wb_dst=3 wb_data=16'h1234 wb_regwrite=1 one cycle later.
- Load addr 16'h0040, ack after 3 cycles with rdata 16'hBEEF -> in_ready low 3 cycles, req stable, wb_data=16'hBEEF.
- Store addr 16'h0010 data 16'h00FF, zero-wait ack -> dmem_we=1 one cycle, no stall, wb_regwrite=0.
- TIMEOUT_CYCLES=4, load never acked -> req drops after 5 cycles, mem_err=1, wb_data=16'hDEAD, wb_regwrite=0; next op proceeds.
- Load with dst=0 -> wb_regwrite=0; back-to-back ALU ops with dst=0 -> fwd_mem_valid=0.
- rst asserted during WAIT -> dmem_req 0 same cycle, all valids 0, mem_err 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: M-bit field indices, the memory-access FSM
// state type and the data substituted for a timed-out load.
package cpu_pkg;

    localparam int M_READ  = 0;
    localparam int M_WRITE = 1;
    localparam int M_TOREG = 2;

    localparam logic [15:0] MEM_TIMEOUT_DATA = 16'hDEAD;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake sequencer: raises the request for a pending access,
// waits for ack and abandons the access after TIMEOUT_CYCLES wait cycles.
module mem_access_fsm
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_ack,
    output logic o_req,
    output logic o_timeout
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    mem_state_e  r_state;
    mem_state_e  w_state_next;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        o_req        = 1'b0;
        o_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (i_start) begin
                    o_req = 1'b1;
                    if (!i_ack) begin
                        w_state_next = WAIT;
                        w_cnt_next   = 16'd1;
                    end
                end
            end
            WAIT: begin
                o_req = i_start;
                // Ack takes priority over an expiring counter.
                if (!i_start || i_ack) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == TIMEOUT_LIMIT) begin
                    o_timeout    = 1'b1;
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM register, data-memory access via
// mem_access_fsm, MEM/WB register and EX forwarding taps.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        WB_in,
    input  logic [2:0]  M_in,
    input  logic [15:0] alu_result,
    input  logic [15:0] store_data,
    input  logic [3:0]  dst,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output logic [3:0]  wb_dst,
    output logic [15:0] wb_data,
    output logic        fwd_mem_valid,
    output logic [3:0]  fwd_mem_dst,
    output logic [15:0] fwd_mem_data,
    output logic        mem_err
);

    logic        r_s1_valid;
    logic        r_s1_wb;
    logic [2:0]  r_s1_m;
    logic [15:0] r_s1_alu;
    logic [15:0] r_s1_sdata;
    logic [3:0]  r_s1_dst;

    logic        r_s2_valid;
    logic        r_s2_regwrite;
    logic [3:0]  r_s2_dst;
    logic [15:0] r_s2_data;
    logic        r_mem_err;

    logic        w_mem_op;
    logic        w_is_write;
    logic        w_start;
    logic        w_req;
    logic        w_timeout;
    logic        w_retire;
    logic        w_regwrite;
    logic [15:0] w_wb_data;

    // A write with mem_read also set is still a write.
    assign w_mem_op   = r_s1_m[M_READ] | r_s1_m[M_WRITE];
    assign w_is_write = r_s1_m[M_WRITE];
    assign w_start    = r_s1_valid & w_mem_op;

    mem_access_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_ack    (dmem_ack),
        .o_req    (w_req),
        .o_timeout(w_timeout)
    );

    assign in_ready   = ~(w_start & ~dmem_ack & ~w_timeout);
    assign w_retire   = r_s1_valid & (~w_mem_op | dmem_ack | w_timeout);
    assign w_regwrite = r_s1_wb & ~w_is_write & (r_s1_dst != 4'd0) & ~w_timeout;
    assign w_wb_data  = w_timeout        ? MEM_TIMEOUT_DATA :
                        r_s1_m[M_TOREG] ? dmem_rdata       : r_s1_alu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_wb    <= 1'b0;
            r_s1_m     <= '0;
            r_s1_alu   <= '0;
            r_s1_sdata <= '0;
            r_s1_dst   <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_wb    <= WB_in;
                r_s1_m     <= M_in;
                r_s1_alu   <= alu_result;
                r_s1_sdata <= store_data;
                r_s1_dst   <= dst;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid    <= 1'b0;
            r_s2_regwrite <= 1'b0;
            r_s2_dst      <= '0;
            r_s2_data     <= '0;
            r_mem_err     <= 1'b0;
        end else begin
            r_s2_valid    <= w_retire;
            r_s2_regwrite <= w_retire & w_regwrite;
            if (w_retire) begin
                r_s2_dst  <= r_s1_dst;
                r_s2_data <= w_wb_data;
            end
            r_mem_err <= r_mem_err | w_timeout;
        end
    end

    assign dmem_req   = w_req;
    assign dmem_we    = w_req & w_is_write;
    assign dmem_addr  = r_s1_alu;
    assign dmem_wdata = r_s1_sdata;

    assign wb_valid    = r_s2_valid;
    assign wb_regwrite = r_s2_regwrite;
    assign wb_dst      = r_s2_dst;
    assign wb_data     = r_s2_data;
    assign mem_err     = r_mem_err;

    // Loads never forward from here; the hazard unit stalls their consumers.
    assign fwd_mem_valid = r_s1_valid & r_s1_wb & ~r_s1_m[M_TOREG] & (r_s1_dst != 4'd0);
    assign fwd_mem_dst   = r_s1_dst;
    assign fwd_mem_data  = r_s1_alu;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table-driven ops with a write-back
// scoreboard, plus hand sequences for forwarding timing and reset mid-access.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        WB_in;
    logic [2:0]  M_in;
    logic [15:0] alu_result;
    logic [15:0] store_data;
    logic [3:0]  dst;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_regwrite;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;
    logic        fwd_mem_valid;
    logic [3:0]  fwd_mem_dst;
    logic [15:0] fwd_mem_data;
    logic        mem_err;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .WB_in        (WB_in),
        .M_in         (M_in),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .dst          (dst),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_regwrite  (wb_regwrite),
        .wb_dst       (wb_dst),
        .wb_data      (wb_data),
        .fwd_mem_valid(fwd_mem_valid),
        .fwd_mem_dst  (fwd_mem_dst),
        .fwd_mem_data (fwd_mem_data),
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wb;
        logic [2:0]  m;
        logic [15:0] alu;
        logic [15:0] sdata;
        logic [3:0]  d;
        int          delay;     // ack cycles after first request; -1 = never
        logic [15:0] rdata;
        logic        exp_fwd;
        logic        exp_we;
        logic        exp_rw;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic        rw;
        logic [3:0]  d;
        logic [15:0] data;
    } wb_exp_t;

    wb_exp_t sb[$];
    int      n_checks = 0;
    int      n_errors = 0;
    int      n_pushed = 0;
    int      n_seen   = 0;
    vec_t    vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input string n, input logic wb, input logic [2:0] m,
                                input logic [15:0] alu, input logic [15:0] sd,
                                input logic [3:0] d, input int dly, input logic [15:0] rd,
                                input logic fwd, input logic we, input logic rw,
                                input logic [15:0] ed, input logic err);
        vec_t v;
        v.name = n; v.wb = wb; v.m = m; v.alu = alu; v.sdata = sd; v.d = d;
        v.delay = dly; v.rdata = rd; v.exp_fwd = fwd; v.exp_we = we;
        v.exp_rw = rw; v.exp_data = ed; v.exp_err = err;
        return v;
    endfunction

    // Write-back monitor: every retired instruction must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            n_seen++;
            if (sb.size() == 0) begin
                check("wb_unexpected", 32'(wb_valid), 32'(1'b0));
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                check("wb_regwrite", 32'(wb_regwrite), 32'(e.rw));
                check("wb_dst", 32'(wb_dst), 32'(e.d));
                check("wb_data", 32'(wb_data), 32'(e.data));
            end
        end
    end

    task automatic push_exp(input logic rw, input logic [3:0] d, input logic [15:0] data);
        wb_exp_t e;
        e.rw = rw; e.d = d; e.data = data;
        sb.push_back(e);
        n_pushed++;
    endtask

    task automatic drive(input logic wb, input logic [2:0] m, input logic [15:0] alu,
                         input logic [15:0] sd, input logic [3:0] d);
        in_valid = 1'b1; WB_in = wb; M_in = m;
        alu_result = alu; store_data = sd; dst = d;
    endtask

    task automatic run_op(input vec_t v);
        logic last;
        drive(v.wb, v.m, v.alu, v.sdata, v.d);
        push_exp(v.exp_rw, v.d, v.exp_data);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (v.m[0] | v.m[1]) begin
            for (int c = 0; c <= TO; c++) begin
                last = (v.delay == c) || (v.delay < 0 && c == TO);
                if (v.delay == c) begin
                    dmem_ack = 1'b1; dmem_rdata = v.rdata;
                end
                @(negedge clk);
                if (c == 0) check({v.name, "_fwd"}, 32'(fwd_mem_valid), 32'(v.exp_fwd));
                check({v.name, "_req"}, 32'(dmem_req), 32'(1'b1));
                check({v.name, "_we"}, 32'(dmem_we), 32'(v.exp_we));
                check({v.name, "_addr"}, 32'(dmem_addr), 32'(v.alu));
                if (v.exp_we) check({v.name, "_wdata"}, 32'(dmem_wdata), 32'(v.sdata));
                check({v.name, "_ready"}, 32'(in_ready), 32'(last));
                @(posedge clk); #1;
                dmem_ack = 1'b0; dmem_rdata = 16'h0;
                if (last) break;
            end
            check({v.name, "_req_drop"}, 32'(dmem_req), 32'(1'b0));
            check({v.name, "_err"}, 32'(mem_err), 32'(v.exp_err));
        end else begin
            @(negedge clk);
            check({v.name, "_fwd"}, 32'(fwd_mem_valid), 32'(v.exp_fwd));
            if (v.exp_fwd) begin
                check({v.name, "_fwd_dst"}, 32'(fwd_mem_dst), 32'(v.d));
                check({v.name, "_fwd_data"}, 32'(fwd_mem_data), 32'(v.alu));
            end
            check({v.name, "_err"}, 32'(mem_err), 32'(v.exp_err));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; WB_in = 1'b0; M_in = 3'b000;
        alu_result = '0; store_data = '0; dst = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;

        //           name     wb  m       alu       sdata     d  dly rdata    fwd we rw data      err
        vecs[0]  = mk("ld_beef", 1, 3'b101, 16'h0040, 16'h0000, 5, 3, 16'hBEEF, 0, 0, 1, 16'hBEEF, 0);
        vecs[1]  = mk("st_zw",   0, 3'b010, 16'h0010, 16'h00FF, 0, 0, 16'h0000, 0, 1, 0, 16'h0010, 0);
        vecs[2]  = mk("ld_r0",   1, 3'b101, 16'h0022, 16'h0000, 0, 1, 16'h5555, 0, 0, 0, 16'h5555, 0);
        vecs[3]  = mk("alu_r0a", 1, 3'b000, 16'h0AAA, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0AAA, 0);
        vecs[4]  = mk("alu_r0b", 1, 3'b000, 16'h0BBB, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0BBB, 0);
        vecs[5]  = mk("rw_both", 1, 3'b011, 16'h0030, 16'h1111, 6, 2, 16'h0000, 1, 1, 0, 16'h0030, 0);
        vecs[6]  = mk("ld_to",   1, 3'b101, 16'h0050, 16'h0000, 7, -1, 16'h0000, 0, 0, 0, 16'hDEAD, 1);
        vecs[7]  = mk("alu_r9",  1, 3'b000, 16'h7777, 16'h0000, 9, 0, 16'h0000, 1, 0, 1, 16'h7777, 1);
        vecs[8]  = mk("alu_nowb",0, 3'b000, 16'h0101, 16'h0000, 4, 0, 16'h0000, 0, 0, 0, 16'h0101, 1);
        vecs[9]  = mk("ld_cafe", 1, 3'b101, 16'h0060, 16'h0000, 2, 0, 16'hCAFE, 0, 0, 1, 16'hCAFE, 1);
        vecs[10] = mk("post_rst",1, 3'b000, 16'h4321, 16'h0000, 8, 0, 16'h0000, 1, 0, 1, 16'h4321, 0);
        vecs[11] = mk("st_post", 0, 3'b010, 16'h0070, 16'hA5A5, 1, 2, 16'h0000, 0, 1, 0, 16'h0070, 0);

        #1;
        check("rst_in_ready", 32'(in_ready), 32'(1'b1));
        check("rst_req", 32'(dmem_req), 32'(1'b0));
        check("rst_we", 32'(dmem_we), 32'(1'b0));
        check("rst_addr", 32'(dmem_addr), 32'h0);
        check("rst_wdata", 32'(dmem_wdata), 32'h0);
        check("rst_wb_valid", 32'(wb_valid), 32'(1'b0));
        check("rst_wb_regwrite", 32'(wb_regwrite), 32'(1'b0));
        check("rst_wb_data", 32'(wb_data), 32'h0);
        check("rst_fwd_valid", 32'(fwd_mem_valid), 32'(1'b0));
        check("rst_fwd_data", 32'(fwd_mem_data), 32'h0);
        check("rst_mem_err", 32'(mem_err), 32'(1'b0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ALU op: forward tap the cycle after capture, write-back one cycle later.
        @(negedge clk);
        drive(1'b1, 3'b000, 16'h1234, 16'h0000, 4'd3);
        push_exp(1'b1, 4'd3, 16'h1234);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("alu_fwd_valid", 32'(fwd_mem_valid), 32'(1'b1));
        check("alu_fwd_dst", 32'(fwd_mem_dst), 32'd3);
        check("alu_fwd_data", 32'(fwd_mem_data), 32'h1234);
        check("alu_wb_early", 32'(wb_valid), 32'(1'b0));
        @(negedge clk);
        check("alu_wb_valid", 32'(wb_valid), 32'(1'b1));
        check("alu_fwd_gone", 32'(fwd_mem_valid), 32'(1'b0));

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // Reset while the access is waiting: request must drop at once.
        @(negedge clk);
        drive(1'b1, 3'b101, 16'h0090, 16'h0000, 4'd10);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_req_idle", 32'(dmem_req), 32'(1'b1));
        @(negedge clk);
        check("mid_req_wait", 32'(dmem_req), 32'(1'b1));
        check("mid_err_before", 32'(mem_err), 32'(1'b1));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(dmem_req), 32'(1'b0));
        check("mid_rst_wb_valid", 32'(wb_valid), 32'(1'b0));
        check("mid_rst_fwd", 32'(fwd_mem_valid), 32'(1'b0));
        check("mid_rst_err", 32'(mem_err), 32'(1'b0));
        check("mid_rst_ready", 32'(in_ready), 32'(1'b1));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_no_retire", 32'(wb_valid), 32'(1'b0));

        run_op(vecs[10]);
        run_op(vecs[11]);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("wb_count", 32'(n_seen), 32'(n_pushed));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
